// File: rtl/bus_dev_pkg.sv
// ---------------------------------------------------------------------------
// bus_dev_pkg
//
// Shared types and constants for the per-device bus port adapter.
//   pckg_t       : one bus packet at the default packet width
//   get_dest()   : extracts the destination ID field (top ID_BITS of a packet)
//   BROADCAST_ID : destination ID that every device accepts
// ---------------------------------------------------------------------------
package bus_dev_pkg;

  localparam int PCKG_SZ_DEF  = 16;
  localparam int ID_BITS_DEF  = 8;
  localparam int BROADCAST_ID = 145;

  typedef logic [PCKG_SZ_DEF-1:0] pckg_t;
  typedef logic [ID_BITS_DEF-1:0] dev_id_t;

  // Destination ID lives in the most significant bits of the packet.
  function automatic dev_id_t get_dest(input pckg_t p);
    return p[PCKG_SZ_DEF-1 -: ID_BITS_DEF];
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// ---------------------------------------------------------------------------
// sync_fifo_fwft
//
// Single-clock first-word fall-through FIFO. The head entry is always visible
// on dout while the FIFO is not empty; pop advances to the next entry, which
// appears one cycle later.
//
// Parameters:
//   WIDTH : data width in bits
//   DEPTH : number of entries, power of 2 and at least 2
//
// Ports:
//   clk   in   clock
//   reset in   synchronous reset, active-low; clears pointers, count,
//              storage and the overflow flag
//   push  in   write din this cycle
//   pop   in   consume the head this cycle (ignored when empty)
//   din   in   write data
//   dout  out  head entry
//   empty out  no entries stored
//   full  out  DEPTH entries stored
//   ovf   out  sticky: a push was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module sync_fifo_fwft #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A pop on an empty FIFO is a no-op. A push into a full FIFO still lands
  // when the head is popped in the same cycle, since that frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + AW'(1);
      end
      if (do_pop) begin
        rptr <= rptr + AW'(1);
      end
      if (push && !do_push) begin
        ovf <= 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rptr];

endmodule

// File: rtl/bus_dev_port.sv
// ---------------------------------------------------------------------------
// bus_dev_port
//
// Per-device adapter between one device and the bus generator/arbiter.
// TX: device writes are buffered and offered to the arbiter through the
//     pndng / pop / D_pop handshake.
// RX: arbiter deliveries are filtered on the destination ID (own ID or
//     broadcast); accepted packets are buffered for the device, rejected
//     ones are counted.
//
// Optional feature, enabled by defining BUS_DEV_PORT_STATS_EN:
//   tx_sent_cnt[15:0] counts accepted pops, rx_acc_cnt[15:0] counts stored
//   RX packets. Both wrap and clear on reset.
//
// Parameters:
//   PCKG_SZ   packet width
//   ID_BITS   destination ID field width, at D[PCKG_SZ-1 -: ID_BITS]
//   MY_ID     this device's ID
//   BROADCAST ID accepted by every device
//   DEPTH     entries per FIFO (power of 2, >= 2)
//
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   pndng, D_pop, pop     arbiter side of the TX FIFO
//   push, D_push          arbiter delivery into the RX filter
//   tx_push, tx_data      device write into the TX FIFO
//   tx_full               TX FIFO full
//   rx_pop, rx_data       device read of the RX FIFO head
//   rx_valid              RX FIFO not empty
//   tx_ovf, rx_ovf        sticky drop flags
//   rx_misroute           saturating count of filtered-out packets
// ---------------------------------------------------------------------------
module bus_dev_port
  import bus_dev_pkg::*;
#(
  parameter int PCKG_SZ   = PCKG_SZ_DEF,
  parameter int ID_BITS   = ID_BITS_DEF,
  parameter int MY_ID     = 0,
  parameter int BROADCAST = BROADCAST_ID,
  parameter int DEPTH     = 8
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  output logic [PCKG_SZ-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [PCKG_SZ-1:0] D_push,
  input  logic               tx_push,
  input  logic [PCKG_SZ-1:0] tx_data,
  output logic               tx_full,
  input  logic               rx_pop,
  output logic [PCKG_SZ-1:0] rx_data,
  output logic               rx_valid,
  output logic               tx_ovf,
  output logic               rx_ovf,
  output logic [7:0]         rx_misroute
`ifdef BUS_DEV_PORT_STATS_EN
  ,
  output logic [15:0]        tx_sent_cnt,
  output logic [15:0]        rx_acc_cnt
`endif
);

  logic               tx_empty;
  logic               rx_empty;
  logic               rx_full;
  logic [ID_BITS-1:0] dest;
  logic               accept;
  logic               rx_push;

  // ---------------- TX path ----------------
  sync_fifo_fwft #(
    .WIDTH (PCKG_SZ),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (pop),
    .din   (tx_data),
    .dout  (D_pop),
    .empty (tx_empty),
    .full  (tx_full),
    .ovf   (tx_ovf)
  );

  assign pndng = !tx_empty;

  // ---------------- RX filter ----------------
  // The package helper is typed for the default packet layout; other
  // layouts slice the field directly.
  generate
    if (PCKG_SZ == PCKG_SZ_DEF && ID_BITS == ID_BITS_DEF) begin : g_dest_pkg
      assign dest = get_dest(D_push);
    end else begin : g_dest_slice
      assign dest = D_push[PCKG_SZ-1 -: ID_BITS];
    end
  endgenerate

  assign accept  = (dest == ID_BITS'(MY_ID)) || (dest == ID_BITS'(BROADCAST));
  assign rx_push = push && accept;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_misroute <= 8'd0;
    end else if (push && !accept && rx_misroute != 8'hFF) begin
      rx_misroute <= rx_misroute + 8'd1;
    end
  end

  // ---------------- RX path ----------------
  sync_fifo_fwft #(
    .WIDTH (PCKG_SZ),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (D_push),
    .dout  (rx_data),
    .empty (rx_empty),
    .full  (rx_full),
    .ovf   (rx_ovf)
  );

  assign rx_valid = !rx_empty;

`ifdef BUS_DEV_PORT_STATS_EN
  // A stored RX packet needs a free slot, or a real pop of the head in the
  // same cycle; this mirrors the FIFO's own write condition.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_sent_cnt <= 16'd0;
      rx_acc_cnt  <= 16'd0;
    end else begin
      if (pop && pndng) begin
        tx_sent_cnt <= tx_sent_cnt + 16'd1;
      end
      if (rx_push && (!rx_full || (rx_pop && rx_valid))) begin
        rx_acc_cnt <= rx_acc_cnt + 16'd1;
      end
    end
  end
`else
  // RX full only feeds the statistics counter; without it the net is
  // intentionally left unread.
  logic rx_full_unused;
  assign rx_full_unused = rx_full;
`endif

endmodule

// File: tb/tb_bus_dev_port.sv
// ---------------------------------------------------------------------------
// tb_bus_dev_port
//
// Self-checking bench for bus_dev_port (MY_ID=3, DEPTH=8). A vector table
// covers the basic TX handshake and RX filtering; hand-written sequences
// cover overflow, simultaneous push/pop, misroute saturation and reset
// in the middle of traffic.
// ---------------------------------------------------------------------------
module tb_bus_dev_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop;
  logic        push;
  logic [15:0] D_push;
  logic        tx_push;
  logic [15:0] tx_data;
  logic        tx_full;
  logic        rx_pop;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        tx_ovf;
  logic        rx_ovf;
  logic [7:0]  rx_misroute;
`ifdef BUS_DEV_PORT_STATS_EN
  logic [15:0] tx_sent_cnt;
  logic [15:0] rx_acc_cnt;
`endif

  int checks = 0;
  int errors = 0;

  bus_dev_port #(
    .PCKG_SZ   (16),
    .ID_BITS   (8),
    .MY_ID     (3),
    .BROADCAST (145),
    .DEPTH     (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pndng       (pndng),
    .D_pop       (D_pop),
    .pop         (pop),
    .push        (push),
    .D_push      (D_push),
    .tx_push     (tx_push),
    .tx_data     (tx_data),
    .tx_full     (tx_full),
    .rx_pop      (rx_pop),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_ovf      (tx_ovf),
    .rx_ovf      (rx_ovf),
    .rx_misroute (rx_misroute)
`ifdef BUS_DEV_PORT_STATS_EN
    ,
    .tx_sent_cnt (tx_sent_cnt),
    .rx_acc_cnt  (rx_acc_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        tx_push;
    logic [15:0] tx_data;
    logic        pop;
    logic        push;
    logic [15:0] d_push;
    logic        rx_pop;
    logic        e_pndng;
    logic [15:0] e_dpop;
    logic        e_tx_full;
    logic        e_rx_valid;
    logic [15:0] e_rx_data;
    logic        e_tx_ovf;
    logic        e_rx_ovf;
    logic [7:0]  e_mis;
  } vec_t;

  vec_t vecs [12];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it in, then return inputs to idle.
  // Outputs are sampled 1 time unit after the edge by the caller.
  task automatic applyStimulus(input logic rst_n, input logic tp,
                               input logic [15:0] td, input logic pp,
                               input logic ps, input logic [15:0] dp,
                               input logic rp);
    reset   = rst_n;
    tx_push = tp;
    tx_data = td;
    pop     = pp;
    push    = ps;
    D_push  = dp;
    rx_pop  = rp;
    @(posedge clk);
    #1;
    reset   = 1'b1;
    tx_push = 1'b0;
    tx_data = 16'h0;
    pop     = 1'b0;
    push    = 1'b0;
    D_push  = 16'h0;
    rx_pop  = 1'b0;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic checkAll(input string tag, input vec_t v);
    checkOutput({tag, ".pndng"},       pndng,       v.e_pndng);
    checkOutput({tag, ".D_pop"},       D_pop,       v.e_dpop);
    checkOutput({tag, ".tx_full"},     tx_full,     v.e_tx_full);
    checkOutput({tag, ".rx_valid"},    rx_valid,    v.e_rx_valid);
    checkOutput({tag, ".rx_data"},     rx_data,     v.e_rx_data);
    checkOutput({tag, ".tx_ovf"},      tx_ovf,      v.e_tx_ovf);
    checkOutput({tag, ".rx_ovf"},      rx_ovf,      v.e_rx_ovf);
    checkOutput({tag, ".rx_misroute"}, rx_misroute, v.e_mis);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t zero_v;
    reset   = 1'b0;
    tx_push = 1'b0;
    tx_data = 16'h0;
    pop     = 1'b0;
    push    = 1'b0;
    D_push  = 16'h0;
    rx_pop  = 1'b0;

    //            rst  txp  tx_data  pop  push d_push   rxp   pnd  D_pop    full rxv  rx_data  tovf rovf mis
    vecs[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 16'h0312, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0312, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 1'b1, 16'h0345, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0312, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0345, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h03AA, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h03AA, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h91BB, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h03AA, 1'b0, 1'b0, 8'd0};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h05CC, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h03AA, 1'b0, 1'b0, 8'd1};
    vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h91BB, 1'b0, 1'b0, 8'd1};
    vecs[9]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd1};
    vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd1};
    vecs[11] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd1};

    // ---- Table: TX handshake and RX filtering ----
    doReset();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].tx_push, vecs[i].tx_data, vecs[i].pop,
                    vecs[i].push, vecs[i].d_push, vecs[i].rx_pop);
      checkAll($sformatf("vec%0d", i), vecs[i]);
    end

    // ---- TX overflow: 9 writes into 8 entries, then drain in order ----
    doReset();
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0);
      checkOutput($sformatf("ovf.tx_full%0d", i), tx_full, (i >= 8) ? 32'd1 : 32'd0);
      checkOutput($sformatf("ovf.tx_ovf%0d", i),  tx_ovf,  (i == 9) ? 32'd1 : 32'd0);
    end
    for (int i = 1; i <= 8; i++) begin
      checkOutput($sformatf("ovf.pndng%0d", i), pndng, 32'd1);
      checkOutput($sformatf("ovf.D_pop%0d", i), D_pop, 32'h1000 + 32'(i));
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    end
    checkOutput("ovf.pndng_end",   pndng,   32'd0);
    checkOutput("ovf.tx_full_end", tx_full, 32'd0);
    checkOutput("ovf.tx_ovf_held", tx_ovf,  32'd1);

    // ---- Simultaneous push/pop while full, then while empty ----
    doReset();
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0, 16'h0, 1'b0);
    end
    checkOutput("sim.full_before", tx_full, 32'd1);
    applyStimulus(1'b1, 1'b1, 16'h2009, 1'b1, 1'b0, 16'h0, 1'b0);
    checkOutput("sim.full_after", tx_full, 32'd1);
    checkOutput("sim.tx_ovf",     tx_ovf,  32'd0);
    for (int i = 2; i <= 9; i++) begin
      checkOutput($sformatf("sim.D_pop%0d", i), D_pop, 32'h2000 + 32'(i));
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    end
    checkOutput("sim.drained", pndng, 32'd0);
    applyStimulus(1'b1, 1'b1, 16'h3000, 1'b1, 1'b0, 16'h0, 1'b0);
    checkOutput("sim.empty_pndng", pndng,   32'd1);
    checkOutput("sim.empty_D_pop", D_pop,   32'h3000);
    checkOutput("sim.empty_full",  tx_full, 32'd0);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    checkOutput("sim.count_one", pndng, 32'd0);

    // ---- Misroute saturation ----
    doReset();
    for (int i = 1; i <= 300; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, {8'h07, 8'(i)}, 1'b0);
      if (i == 254) begin
        checkOutput("mis.at254", rx_misroute, 32'd254);
      end
    end
    checkOutput("mis.saturated", rx_misroute, 32'd255);
    checkOutput("mis.rx_valid",  rx_valid,    32'd0);

    // ---- Reset in the middle of traffic ----
    doReset();
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0700, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 1'b1, 16'h4000 + 16'(i), 1'b0, 1'b1, 16'h0300 + 16'(i), 1'b0);
    end
    checkOutput("mid.tx_ovf_set", tx_ovf,      32'd1);
    checkOutput("mid.rx_ovf_set", rx_ovf,      32'd1);
    checkOutput("mid.mis_set",    rx_misroute, 32'd1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b1);
    end
    checkOutput("mid.D_pop_half",   D_pop,   32'h4005);
    checkOutput("mid.rx_data_half", rx_data, 32'h0305);
    applyStimulus(1'b0, 1'b1, 16'h4444, 1'b1, 1'b1, 16'h0399, 1'b1);
    zero_v = '{1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0,
               1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 8'd0};
    checkAll("mid.reset", zero_v);
    applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    checkAll("mid.after", zero_v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
